// File: rtl/fftseq_capture_writer.sv
// rtl/fftseq_capture_writer.sv - stereo sample capture into the split L/R waveform DPRAM
//
// Purpose: takes one stereo pair per SampleValid strobe and writes L to the
// lower half and R to the upper half of the DPRAM, one sample per cycle.
// After N pairs it pulses FrameDone and holds (FULL) until Arm.
//
// Ports:
//   Clock, Reset         clock (rising edge), async active-high reset
//   SampleValid          one-cycle strobe qualifying SampleL/SampleR
//   SampleL, SampleR     left/right samples, passed through unmodified
//   Arm                  consumer done with the RAM; restart capture (FULL only)
//   ClearOverrun         clears the sticky Overrun flag
//   WrAddr/WrData/WrEn   DPRAM write port, WrAddr = {channel, index}
//   FrameDone            one-cycle pulse when a frame is complete
//   Capturing            high while samples are accepted (state != FULL)
//   Overrun              sticky, a sample was dropped
module fftseq_capture_writer #(
  parameter int bw_dpram = 12,
  parameter int bw_data  = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                SampleValid,
  input  logic [bw_data-1:0]  SampleL,
  input  logic [bw_data-1:0]  SampleR,
  input  logic                Arm,
  input  logic                ClearOverrun,
  output logic [bw_dpram-1:0] WrAddr,
  output logic [bw_data-1:0]  WrData,
  output logic                WrEn,
  output logic                FrameDone,
  output logic                Capturing,
  output logic                Overrun
);

  localparam int bw_idx = bw_dpram - 1;
  localparam logic [bw_idx-1:0] idx_one  = 1;
  localparam logic [bw_idx-1:0] idx_last = '1;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_WRITE_R = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [bw_idx-1:0]   index_q, index_d;
  logic [bw_data-1:0]  hold_r_q, hold_r_d;
  logic [bw_dpram-1:0] wr_addr_q, wr_addr_d;
  logic [bw_data-1:0]  wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                done_pending_q, done_pending_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                drop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_WAIT;
      index_q        <= '0;
      hold_r_q       <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_en_q        <= 1'b0;
      done_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      hold_r_q       <= hold_r_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_en_q        <= wr_en_d;
      done_pending_q <= done_pending_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    hold_r_d       = hold_r_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    wr_en_d        = 1'b0;
    done_pending_d = 1'b0;
    // FrameDone trails the last R write by one cycle, hence the extra stage.
    frame_done_d   = done_pending_q;
    overrun_d      = overrun_q;
    drop           = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (SampleValid) begin
          wr_addr_d = {1'b0, index_q};
          wr_data_d = SampleL;
          wr_en_d   = 1'b1;
          hold_r_d  = SampleR;
          state_d   = ST_WRITE_R;
        end
      end
      ST_WRITE_R: begin
        wr_addr_d = {1'b1, index_q};
        wr_data_d = hold_r_q;
        wr_en_d   = 1'b1;
        drop      = SampleValid;
        if (index_q == idx_last) begin
          index_d        = '0;
          state_d        = ST_FULL;
          done_pending_d = 1'b1;
        end else begin
          index_d = index_q + idx_one;
          state_d = ST_WAIT;
        end
      end
      ST_FULL: begin
        // A strobe coincident with Arm is still dropped; only the next one counts.
        drop = SampleValid;
        if (Arm) begin
          index_d = '0;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Setting wins over clearing in the same cycle.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (ClearOverrun) begin
      overrun_d = 1'b0;
    end
  end

  assign WrAddr    = wr_addr_q;
  assign WrData    = wr_data_q;
  assign WrEn      = wr_en_q;
  assign FrameDone = frame_done_q;
  assign Capturing = (state_q != ST_FULL);
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_fftseq_capture_writer.sv
// tb/tb_fftseq_capture_writer.sv - scoreboard bench for fftseq_capture_writer
module tb_fftseq_capture_writer;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          SampleValid = 1'b0;
  logic [DW-1:0] SampleL = '0;
  logic [DW-1:0] SampleR = '0;
  logic          Arm = 1'b0;
  logic          ClearOverrun = 1'b0;
  logic [AW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  logic          WrEn;
  logic          FrameDone;
  logic          Capturing;
  logic          Overrun;

  fftseq_capture_writer #(.bw_dpram(AW), .bw_data(DW)) dut (
    .Clock(Clock), .Reset(Reset), .SampleValid(SampleValid),
    .SampleL(SampleL), .SampleR(SampleR), .Arm(Arm), .ClearOverrun(ClearOverrun),
    .WrAddr(WrAddr), .WrData(WrData), .WrEn(WrEn), .FrameDone(FrameDone),
    .Capturing(Capturing), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_idx   = 0;
  logic [AW+DW-1:0] wq[$];
  int               dq[$];

  always @(posedge Clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals a frame.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (WrEn) begin
        if (wq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write (cycle %0d)", WrAddr, WrData, cyc);
        end else begin
          logic [AW+DW-1:0] e;
          e = wq.pop_front();
          check("write_addr", {28'd0, WrAddr}, {28'd0, e[AW+DW-1:DW]});
          check("write_data", {16'd0, WrData}, {16'd0, e[DW-1:0]});
        end
      end
      if (FrameDone) begin
        if (dq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_framedone: got pulse expected none (cycle %0d)", cyc);
        end else begin
          check("framedone_cycle", cyc, dq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One-cycle strobe; when accepted the L/R writes and, on the last pair,
  // the FrameDone cycle (strobe cycle + 3) are pushed to the scoreboard.
  task automatic strobe(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit acc);
    logic [AW-2:0] ix;
    SampleValid = 1'b1;
    SampleL = l;
    SampleR = r;
    if (acc) begin
      ix = m_idx[AW-2:0];
      wq.push_back({1'b0, ix, l});
      wq.push_back({1'b1, ix, r});
      m_idx++;
      if (m_idx == 8) begin
        dq.push_back(cyc + 3);
        m_idx = 0;
      end
    end
    tick();
    SampleValid = 1'b0;
    SampleL = '0;
    SampleR = '0;
    Arm = 1'b0;
    ClearOverrun = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wraddr"}, {28'd0, WrAddr}, 32'd0);
    check({tag, "_wrdata"}, {16'd0, WrData}, 32'd0);
    check({tag, "_wren"}, {31'd0, WrEn}, 32'd0);
    check({tag, "_framedone"}, {31'd0, FrameDone}, 32'd0);
    check({tag, "_overrun"}, {31'd0, Overrun}, 32'd0);
    check({tag, "_capturing"}, {31'd0, Capturing}, 32'd1);
  endtask

  initial begin
    idle(3);
    check_reset_vals("reset");
    Reset = 1'b0;
    tick();

    // Full frame with 4-cycle spacing.
    for (int i = 0; i < 8; i++) begin
      strobe(16'h0100 + 16'(i), 16'h8000 + 16'(i), 1'b1);
      idle(3);
    end
    check("capturing_after_frame", {31'd0, Capturing}, 32'd0);
    check("no_overrun_frame1", {31'd0, Overrun}, 32'd0);

    // Strobes while FULL are all dropped.
    for (int i = 0; i < 5; i++) begin
      strobe(16'h1111, 16'h2222, 1'b0);
      tick();
    end
    check("overrun_in_full", {31'd0, Overrun}, 32'd1);
    ClearOverrun = 1'b1;
    tick();
    ClearOverrun = 1'b0;
    check("overrun_cleared", {31'd0, Overrun}, 32'd0);

    // ClearOverrun coincident with a dropped sample: set wins.
    ClearOverrun = 1'b1;
    strobe(16'h3333, 16'h4444, 1'b0);
    check("overrun_set_beats_clear", {31'd0, Overrun}, 32'd1);
    ClearOverrun = 1'b1;
    tick();
    ClearOverrun = 1'b0;
    check("overrun_cleared2", {31'd0, Overrun}, 32'd0);

    Arm = 1'b1;
    tick();
    Arm = 1'b0;
    check("capturing_after_arm", {31'd0, Capturing}, 32'd1);
    strobe(16'h0A00, 16'hBA00, 1'b1);
    tick();

    // Back-to-back: middle strobe dropped.
    strobe(16'h0A01, 16'hBA01, 1'b1);
    strobe(16'hDEAD, 16'hBEEF, 1'b0);
    strobe(16'h0A02, 16'hBA02, 1'b1);
    tick();
    check("overrun_back_to_back", {31'd0, Overrun}, 32'd1);
    for (int i = 3; i < 8; i++) begin
      strobe(16'h0A00 + 16'(i), 16'hBA00 + 16'(i), 1'b1);
      tick();
    end
    idle(2);
    check("capturing_after_frame2", {31'd0, Capturing}, 32'd0);

    // Arm with a coincident strobe: dropped, then next cycle accepted at index 0.
    ClearOverrun = 1'b1;
    tick();
    ClearOverrun = 1'b0;
    Arm = 1'b1;
    strobe(16'h5555, 16'h6666, 1'b0);
    check("arm_strobe_overrun", {31'd0, Overrun}, 32'd1);
    check("arm_strobe_capturing", {31'd0, Capturing}, 32'd1);
    strobe(16'h0C00, 16'hCC00, 1'b1);
    tick();
    strobe(16'h0C01, 16'hCC01, 1'b1);
    tick();
    strobe(16'h0C02, 16'hCC02, 1'b1);
    idle(2);

    // Mid-frame reset after 3 pairs abandons the partial frame.
    Reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    tick();
    Reset = 1'b0;
    m_idx = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      strobe(16'h0D00 + 16'(i), 16'hED00 + 16'(i), 1'b1);
      tick();
    end
    idle(5);
    check("capturing_after_frame3", {31'd0, Capturing}, 32'd0);
    check("writes_drained", wq.size(), 32'd0);
    check("framedones_drained", dq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
